// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: FIFO-buffered word launcher for spi_master, paced by cs; define SPI_TX_FEEDER_STATS_EN for sent/drop counters
module spi_tx_feeder #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 64,
  parameter int GAP_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   din,
  output logic                    new_data,
  input  logic                    cs,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    timeout_err
`ifdef SPI_TX_FEEDER_STATS_EN
  ,
  output logic [15:0]             sent_count,
  output logic [7:0]              drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2((TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES) + 1);
  localparam logic [1:0] IDLE = 2'd0, LAUNCH = 2'd1, ACTIVE = 2'd2, GAP = 2'd3;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [1:0] state;
  logic [CW-1:0] timer;
  logic cs_q, fall, rise, wr, pop, expire;
  assign fall = cs_q & ~cs;
  assign rise = ~cs_q & cs;
  assign wr_ready = level != LW'(DEPTH);
  assign wr = wr_valid & wr_ready;
  assign pop = state == LAUNCH && fall;
  // a fall on the expiry edge wins over the timeout
  assign expire = state == LAUNCH && !fall && timer == CW'(TIMEOUT);
  assign busy = state != IDLE || level != '0;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wr_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp          <= '0;
      rp          <= '0;
      level       <= '0;
      din         <= '0;
      new_data    <= 1'b0;
      timeout_err <= 1'b0;
      state       <= IDLE;
      cs_q        <= 1'b1;
      timer       <= '0;
    end else begin
      cs_q        <= cs;
      wp          <= wp + AW'(wr);
      rp          <= rp + AW'(pop);
      level       <= level + LW'(wr) - LW'(pop);
      timeout_err <= expire;
      case (state)
        IDLE:
          if (level != '0) begin
            state    <= LAUNCH;
            din      <= mem[rp];
            new_data <= 1'b1;
            timer    <= '0;
          end
        LAUNCH: begin
          timer <= timer + 1'b1;
          if (fall || expire) new_data <= 1'b0;
          if (fall) state <= ACTIVE;
          else if (expire) begin
            state <= GAP;
            timer <= '0;
          end
        end
        ACTIVE:
          if (rise) begin
            state <= GAP;
            timer <= '0;
          end
        GAP: begin
          timer <= timer + 1'b1;
          if (timer == CW'(GAP_CYCLES - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef SPI_TX_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sent_count <= '0;
      drop_count <= '0;
    end else begin
      sent_count <= sent_count + 16'(pop);
      drop_count <= drop_count + 8'(expire && drop_count != 8'hFF);
    end
`endif
endmodule

// File: tb/tb_spi_tx_feeder.sv
// tb_spi_tx_feeder: directed stimulus with a scoreboard of words expected to be sent to spi_master
module tb_spi_tx_feeder;
  localparam int T = 64, G = 4;
  logic clk = 0, reset = 0, wr_valid = 0, cs = 1;
  logic [11:0] wr_data = 0, din;
  logic wr_ready, new_data, busy, timeout_err;
  logic [3:0] level;
`ifdef SPI_TX_FEEDER_STATS_EN
  logic [15:0] sent_count;
  logic [7:0] drop_count;
`endif
  int compared = 0, mismatched = 0, cyc = 0, launches = 0;
  int c1, c2, rc, l0;
  logic cs_prev = 1, nd_prev = 0;
  logic [11:0] q[$];

  spi_tx_feeder dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .din(din), .new_data(new_data), .cs(cs), .busy(busy), .level(level), .timeout_err(timeout_err)
`ifdef SPI_TX_FEEDER_STATS_EN
    , .sent_count(sent_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // a word counts as sent when cs falls while new_data is up
  always @(negedge clk)
    if (!reset) begin
      cs_prev <= 1'b1;
      nd_prev <= 1'b0;
    end else begin
      if (new_data && !cs && cs_prev) begin
        if (q.size() == 0) chk("sb_unexpected_send", 0, 1);
        else chk("sent_word", din, q.pop_front());
      end
      if (new_data && !nd_prev) launches <= launches + 1;
      cs_prev <= cs;
      nd_prev <= new_data;
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [11:0] d, input bit acc);
    wr_data = d;
    wr_valid = 1;
    chk("wr_ready_before_write", wr_ready, acc);
    if (acc) q.push_back(d);
    tick();
    wr_valid = 0;
  endtask

  task automatic reset_dut;
    reset = 0;
    q.delete();
    cs = 1;
    wr_valid = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic wait_nd(input string name);
    int n = 0;
    while (!new_data && n < 300) begin
      tick();
      n++;
    end
    chk(name, new_data, 1);
  endtask

  task automatic wait_err(input string name);
    int n = 0;
    while (!timeout_err && n < 300) begin
      tick();
      n++;
    end
    chk(name, timeout_err, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    chk("rst_level", level, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_din", din, 0);
    chk("rst_new_data", new_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    reset = 1;
    tick();
    // single word, cs falls 3 cycles after new_data
    write(12'hA5C, 1);
    chk("t1_level_after_write", level, 1);
    chk("t1_nd_not_yet", new_data, 0);
    tick();
    chk("t1_nd_launch", new_data, 1);
    chk("t1_din", din, 12'hA5C);
    tick();
    tick();
    cs = 0;
    chk("t1_level_before_fall", level, 1);
    tick();
    chk("t1_level_after_fall", level, 0);
    chk("t1_nd_dropped", new_data, 0);
    chk("t1_busy_active", busy, 1);
    cs = 1;
    tick();
    repeat (4) tick();
    chk("t1_busy_idle", busy, 0);
`ifdef SPI_TX_FEEDER_STATS_EN
    chk("t1_sent_count", sent_count, 1);
`endif
    // fill the FIFO with cs held high; head retries on timeout
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      write(12'(12'h123 + i), 1);
      if (i == 0) c1 = cyc;
    end
    write(12'h7AA, 0);
    chk("t2_level_full", level, 8);
    chk("t2_wr_ready_full", wr_ready, 0);
    chk("t2_nd", new_data, 1);
    chk("t2_din", din, 12'h123);
    wait_err("t2_err1_seen");
    chk("t2_err1_cycle", cyc - c1, T + 2);
    c2 = cyc;
    chk("t2_err1_din", din, 12'h123);
    chk("t2_err1_level", level, 8);
    chk("t2_err1_nd", new_data, 0);
    tick();
    chk("t2_err_pulse_width", timeout_err, 0);
    wait_err("t2_err2_seen");
    chk("t2_err_period", cyc - c2, T + G + 2);
`ifdef SPI_TX_FEEDER_STATS_EN
    chk("t2_drop_count", drop_count, 2);
`endif
    // full FIFO: pop and write on the same edge -> write rejected
    wait_nd("t4_relaunch");
    cs = 0;
    wr_data = 12'h7FF;
    wr_valid = 1;
    chk("t4_wr_ready_full", wr_ready, 0);
    tick();
    wr_valid = 0;
    chk("t4_level", level, 7);
    chk("t4_nd", new_data, 0);
    chk("t4_wr_ready", wr_ready, 1);
`ifdef SPI_TX_FEEDER_STATS_EN
    chk("t4_sent_count", sent_count, 1);
    chk("t4_drop_count", drop_count, 2);
`endif
    // async reset in ACTIVE with 5 words queued
    reset_dut();
    for (int i = 0; i < 6; i++) write(12'(12'h201 + i), 1);
    cs = 0;
    tick();
    chk("t5_level_active", level, 5);
    chk("t5_busy_active", busy, 1);
    #2;
    reset = 0;
    #1;
    chk("t5_nd_async", new_data, 0);
    chk("t5_level_async", level, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_wr_ready_async", wr_ready, 1);
    q.delete();
    cs = 1;
    tick();
    reset = 1;
    // three words, cs low 60 cycles each; gap after each rise
    l0 = launches;
    write(12'h001, 1);
    write(12'h002, 1);
    write(12'h003, 1);
    for (int k = 0; k < 3; k++) begin
      wait_nd("t3_launch");
      if (k > 0) chk("t3_gap_after_rise", cyc - rc, G + 1);
      cs = 0;
      repeat (60) tick();
      cs = 1;
      tick();
      rc = cyc;
    end
    repeat (10) tick();
    chk("t3_launch_count", launches - l0, 3);
    chk("t3_busy_end", busy, 0);
    chk("t3_nd_end", new_data, 0);
    // fall on the exact timeout-expiry edge
    reset_dut();
    write(12'h5A5, 1);
    c1 = cyc;
    while (cyc < c1 + T + 1) tick();
    chk("t6_nd_before", new_data, 1);
    chk("t6_err_before", timeout_err, 0);
    cs = 0;
    tick();
    chk("t6_no_err", timeout_err, 0);
    chk("t6_nd", new_data, 0);
    chk("t6_level", level, 0);
    chk("t6_busy", busy, 1);
`ifdef SPI_TX_FEEDER_STATS_EN
    chk("t6_sent_count", sent_count, 1);
    chk("t6_drop_count", drop_count, 0);
`endif
    cs = 1;
    repeat (6) tick();
    chk("t6_busy_end", busy, 0);
    chk("t6_err_end", timeout_err, 0);
    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
